// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
package pipe_ctrl_pkg;

    localparam int unsigned StallBusW = 6;

    // StallBus: [0] pc, [1] if/id, [2] id/ex, [3] ex/mem, [4] mem/wb, [5] reserved
    typedef logic [StallBusW-1:0] stall_bus_t;

    localparam stall_bus_t StallNone = 6'b000000;
    localparam stall_bus_t StallId   = 6'b000111;  // load-use: hold pc, if/id, bubble into EX
    localparam stall_bus_t StallEx   = 6'b001111;  // multi-cycle: hold EX, bubble into MEM

    typedef enum logic [1:0] {
        CtrlIdle   = 2'd0,
        CtrlMcWait = 2'd1,
        CtrlFlush  = 2'd2
    } ctrl_state_e;

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: arbitrates flush > multi-cycle > load-use
// and owns the multi-cycle occupancy counter so EX only issues a start pulse.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MC_W   = 6,
    parameter int unsigned STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              mc_start,
    input  logic [MC_W-1:0]   mc_len,
    input  logic              flush_req,
    input  logic [31:0]       flush_pc,
    output logic [5:0]        stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              mc_busy,
    output logic [STAT_W-1:0] stall_cycles
);

    ctrl_state_e       state_q;
    logic [MC_W-1:0]   cnt_q;
    logic              flush_q;
    logic [31:0]       new_pc_q;
    logic              mc_busy_q;
    logic [STAT_W-1:0] stall_cycles_q;

    logic              mc_go_c;
    stall_bus_t        stall_c;

    // A multi-cycle op is only accepted from IDLE with a non-zero length.
    assign mc_go_c = (state_q == CtrlIdle) && mc_start && (mc_len != '0);

    // Same-cycle stall vector; flush request or FLUSH state suppresses every stall.
    always_comb begin
        stall_c = StallNone;
        if (flush_req || (state_q == CtrlFlush)) begin
            stall_c = StallNone;
        end else if ((state_q == CtrlMcWait) || mc_go_c) begin
            stall_c = StallEx;
        end else if (stallreq_id) begin
            stall_c = StallId;
        end
    end

    // Control FSM with inline occupancy counter and registered flush/redirect/busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= CtrlIdle;
            cnt_q     <= '0;
            flush_q   <= 1'b0;
            new_pc_q  <= '0;
            mc_busy_q <= 1'b0;
        end else if (flush_req) begin
            state_q   <= CtrlFlush;
            cnt_q     <= '0;
            flush_q   <= 1'b1;
            new_pc_q  <= flush_pc;
            mc_busy_q <= 1'b0;
        end else begin
            unique case (state_q)
                CtrlIdle: begin
                    flush_q <= 1'b0;
                    if (mc_go_c) begin
                        cnt_q <= mc_len - MC_W'(1);
                        if (mc_len >= MC_W'(2)) begin
                            state_q   <= CtrlMcWait;
                            mc_busy_q <= 1'b1;
                        end
                    end
                end
                CtrlMcWait: begin
                    cnt_q <= cnt_q - MC_W'(1);
                    if (cnt_q <= MC_W'(1)) begin
                        state_q   <= CtrlIdle;
                        mc_busy_q <= 1'b0;
                    end
                end
                CtrlFlush: begin
                    state_q <= CtrlIdle;
                    flush_q <= 1'b0;
                end
                default: begin
                    state_q   <= CtrlIdle;
                    cnt_q     <= '0;
                    flush_q   <= 1'b0;
                    mc_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
        end else if (stall_c[0] && (stall_cycles_q != {STAT_W{1'b1}})) begin
            stall_cycles_q <= stall_cycles_q + STAT_W'(1);
        end
    end

    assign stall        = stall_c;
    assign flush        = flush_q;
    assign new_pc       = new_pc_q;
    assign mc_busy      = mc_busy_q;
    assign stall_cycles = stall_cycles_q;

endmodule : pipe_ctrl
